// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - ID-side issue handshake and stage control-bundle outputs of pipe_control_unit
interface pipe_control_unit_if #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_STAGES = 3
);
    logic                       id_valid;
    logic [3:0]                 opcode;
    logic [5:0]                 func_code;
    logic                       stall;
    logic                       flush;
    logic                       id_ready;
    logic [18*NUM_STAGES-1:0]   stage_ctrl;
    logic                       illegal;
    logic                       halted;
    logic [WORD_SIZE-1:0]       retire_cnt;

    modport master (
        output id_valid, opcode, func_code, stall, flush,
        input  id_ready, stage_ctrl, illegal, halted, retire_cnt
    );

    modport slave (
        input  id_valid, opcode, func_code, stall, flush,
        output id_ready, stage_ctrl, illegal, halted, retire_cnt
    );
endinterface

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - TSC ID decode, stage control-bundle pipeline and HLT drain FSM; retire counter under CTRL_RETIRE_CNT_EN
module pipe_control_unit #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_STAGES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    pipe_control_unit_if.slave bus
);
    localparam int CNT_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_RTY = 4'd15;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    typedef struct packed {
        logic       valid;
        logic       hlt;
        logic       wwd;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] br_cond;
        logic       jmp;
        logic       jreg;
        logic [1:0] reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       link;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] drain_cnt_q;
    ctrl_t            stage_q [NUM_STAGES];
    logic             ill_seen_q;
    logic             illegal_q;
    logic             halted_q;

    ctrl_t dec;
    ctrl_t stage0_d;
    logic  dec_ill;
    logic  accept;
    logic  issue;
    logic  ill_seen_d;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec_ill   = 1'b0;
        case (bus.opcode)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                dec.branch  = 1'b1;
                dec.br_cond = bus.opcode[1:0];
                dec.alu_op  = 2'b11;
            end
            OP_ADI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b01;
                dec.alu_src   = 1'b1;
            end
            OP_LHI: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                dec.alu_src   = 1'b1;
            end
            OP_LWD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_SWD: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_JMP: dec.jmp = 1'b1;
            OP_JAL: begin
                dec.jmp       = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
                dec.reg_dst   = 2'b10;
                dec.alu_op    = 2'b11;
            end
            OP_RTY: begin
                case (bus.func_code)
                    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: begin
                        dec.reg_write = 1'b1;
                        dec.reg_dst   = 2'b01;
                        dec.alu_op    = 2'b11;
                    end
                    FN_JPR: dec.jreg = 1'b1;
                    FN_JRL: begin
                        dec.jreg      = 1'b1;
                        dec.link      = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.reg_dst   = 2'b10;
                        dec.alu_op    = 2'b11;
                    end
                    FN_WWD:  dec.wwd = 1'b1;
                    FN_HLT:  dec.hlt = 1'b1;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign accept     = (state_q == ST_RUN) && !bus.stall && !bus.flush;
    assign issue      = accept && bus.id_valid && !dec_ill;
    assign ill_seen_d = accept && bus.id_valid && dec_ill;
    assign stage0_d   = issue ? dec : '0;

    // stall/flush only gate stage 0; downstream stages keep draining
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            ill_seen_q  <= 1'b0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= stage0_d;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_q[k] <= (state_q == ST_HALTED) ? '0 : stage_q[k-1];
            end
            ill_seen_q <= ill_seen_d;
            illegal_q  <= ill_seen_q;
            case (state_q)
                ST_RUN: begin
                    if (issue && dec.hlt) begin
                        if (NUM_STAGES == 1) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= CNT_W'(NUM_STAGES - 1);
                        end
                    end
                end
                // halted rises on the edge that moves HLT into the last stage
                ST_DRAIN: begin
                    if (drain_cnt_q <= CNT_W'(1)) begin
                        state_q     <= ST_HALTED;
                        halted_q    <= 1'b1;
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_flat
        assign bus.stage_ctrl[18*k +: 18] = stage_q[k];
    end

    assign bus.id_ready = accept;
    assign bus.illegal  = illegal_q;
    assign bus.halted   = halted_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [WORD_SIZE-1:0] retire_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_q <= '0;
        end else if (stage_q[NUM_STAGES-1].valid) begin
            retire_q <= retire_q + WORD_SIZE'(1);
        end
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - scoreboard bench for pipe_control_unit with a reference model of the control pipeline
module tb_pipe_control_unit;
    localparam int WS = 16;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_control_unit_if #(.WORD_SIZE(WS), .NUM_STAGES(NS)) bus();
    pipe_control_unit #(.WORD_SIZE(WS), .NUM_STAGES(NS)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [18*NS-1:0] st;
        logic             ill;
        logic             hal;
        logic [WS-1:0]    rcnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [17:0]   m_pipe [NS];
    bit            m_stop   = 0;
    bit            m_halted = 0;
    bit            m_ill_p  = 0;
    bit            m_ill    = 0;
    logic [WS-1:0] m_ret    = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // bit 18 = illegal, [17:0] = bundle with valid set
    function automatic logic [18:0] ref_decode(input logic [3:0] op, input logic [5:0] fn);
        logic [17:0] b;
        bit rt, alu, jpr, jrl, wwd, hlt, br, jmp, jal, adi, ori, lhi, lwd, swd, ill;
        rt  = (op == 4'd15);
        alu = rt && (fn <= 6'd7);
        jpr = rt && (fn == 6'd25);
        jrl = rt && (fn == 6'd26);
        wwd = rt && (fn == 6'd28);
        hlt = rt && (fn == 6'd29);
        br  = (op <= 4'd3);
        jmp = (op == 4'd9);
        jal = (op == 4'd10);
        adi = (op == 4'd4);
        ori = (op == 4'd5);
        lhi = (op == 4'd6);
        lwd = (op == 4'd7);
        swd = (op == 4'd8);
        ill = (op >= 4'd11 && op <= 4'd14) || (rt && !(alu || jpr || jrl || wwd || hlt));
        b       = '0;
        b[17]   = 1'b1;
        b[16]   = hlt;
        b[15]   = wwd;
        b[14]   = alu || adi || ori || lhi || lwd || jal || jrl;
        b[13]   = lwd;
        b[12]   = lwd;
        b[11]   = swd;
        b[10]   = br;
        b[9:8]  = br ? op[1:0] : 2'b00;
        b[7]    = jmp || jal;
        b[6]    = jpr || jrl;
        b[5:4]  = (jal || jrl) ? 2'b10 : (alu ? 2'b01 : 2'b00);
        b[3:2]  = ori ? 2'b01 : (lhi ? 2'b10 : ((alu || jrl || jal || br) ? 2'b11 : 2'b00));
        b[1]    = adi || ori || lhi || lwd || swd;
        b[0]    = jal || jrl;
        return {ill, b};
    endfunction

    initial begin
        logic [18:0] d;
        bit          rdy, iss;
        exp_t        e;
        for (int k = 0; k < NS; k++) m_pipe[k] = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int k = 0; k < NS; k++) m_pipe[k] = '0;
                m_stop = 0; m_halted = 0; m_ill_p = 0; m_ill = 0; m_ret = '0;
            end else begin
                d   = ref_decode(bus.opcode, bus.func_code);
                rdy = !m_stop && !bus.stall && !bus.flush;
                iss = rdy && bus.id_valid && !d[18];
                if (m_pipe[NS-1][17]) m_ret = m_ret + WS'(1);
                for (int k = NS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
                m_pipe[0] = iss ? d[17:0] : 18'h0;
                m_ill   = m_ill_p;
                m_ill_p = rdy && bus.id_valid && d[18];
                if (iss && d[16]) m_stop = 1;
                if (m_pipe[NS-1][16]) m_halted = 1;
            end
            for (int k = 0; k < NS; k++) e.st[18*k +: 18] = m_pipe[k];
            e.ill = m_ill;
            e.hal = m_halted;
`ifdef CTRL_RETIRE_CNT_EN
            e.rcnt = m_ret;
`else
            e.rcnt = '0;
`endif
            sb.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stage_ctrl", bus.stage_ctrl, e.st);
                check("illegal", bus.illegal, e.ill);
                check("halted", bus.halted, e.hal);
                check("retire_cnt", bus.retire_cnt, e.rcnt);
                check("id_ready", bus.id_ready, !m_stop && !bus.stall && !bus.flush);
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] op, input logic [5:0] fn,
                        input bit st, input bit fl, input bit rn);
        reset_n       = rn;
        bus.id_valid  = v;
        bus.opcode    = op;
        bus.func_code = fn;
        bus.stall     = st;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 6'd0, 0, 0, 1);
    endtask

    initial begin
        logic [5:0] fns [12];
        logic [3:0] op;
        logic [5:0] fn;
        fns = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd29};
        bus.id_valid = 0; bus.opcode = '0; bus.func_code = '0; bus.stall = 0; bus.flush = 0;
        @(posedge clk); #1;
        step(0, 4'd0, 6'd0, 0, 0, 0);
        check("reset_stages", bus.stage_ctrl, 0);
        check("reset_halted", bus.halted, 0);
        check("reset_ready", bus.id_ready, 1);

        step(1, 4'd15, 6'd0, 0, 0, 1);
        check("add_s0", bus.stage_ctrl[17:0], 18'h2401C);
        idle(2);
        check("add_s2", bus.stage_ctrl[53:36], 18'h2401C);

        step(1, 4'd7, 6'd0, 1, 0, 1);
        check("lwd_stall_s0", bus.stage_ctrl[17:0], 0);
        check("lwd_stall_ready", bus.id_ready, 0);
        step(1, 4'd7, 6'd0, 0, 0, 1);
        check("lwd_s0", bus.stage_ctrl[17:0], 18'h27002);

        step(1, 4'd15, 6'd0, 0, 0, 1);
        step(1, 4'd15, 6'd29, 0, 0, 1);
        check("hlt_ready", bus.id_ready, 0);
        step(1, 4'd15, 6'd0, 0, 0, 1);
        check("hlt_add_dropped", bus.stage_ctrl[17:0], 0);
        idle(1);
        check("hlt_halted", bus.halted, 1);
        check("hlt_in_s2", bus.stage_ctrl[52], 1);
        idle(3);
        check("halted_empty", bus.stage_ctrl, 0);
        check("halted_ready", bus.id_ready, 0);

        step(0, 4'd0, 6'd0, 0, 0, 0);
        step(1, 4'd15, 6'd29, 0, 0, 1);
        idle(1);
        step(0, 4'd0, 6'd0, 0, 0, 0);
        check("drain_rst_halted", bus.halted, 0);
        check("drain_rst_stages", bus.stage_ctrl, 0);
        check("drain_rst_ready", bus.id_ready, 1);
        step(1, 4'd5, 6'd0, 0, 0, 1);
        check("ori_s0", bus.stage_ctrl[17:0], 18'h24006);

        step(1, 4'd12, 6'd0, 0, 0, 1);
        check("ill12_s0", bus.stage_ctrl[17:0], 0);
        check("ill12_early", bus.illegal, 0);
        idle(1);
        check("ill12_pulse", bus.illegal, 1);
        idle(1);
        check("ill12_end", bus.illegal, 0);
        step(1, 4'd15, 6'h3F, 0, 0, 1);
        check("ill3f_s0", bus.stage_ctrl[17:0], 0);
        idle(1);
        check("ill3f_pulse", bus.illegal, 1);
        idle(1);
        check("ill3f_end", bus.illegal, 0);

        for (int i = 0; i < 1500; i++) begin
            if (m_halted || $urandom_range(0, 99) == 0) begin
                step(0, 4'd0, 6'd0, 0, 0, 0);
            end else begin
                op = 4'($urandom_range(0, 15));
                fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
                step($urandom_range(0, 7) != 0, op, fn,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 1);
            end
        end

`ifdef CTRL_RETIRE_CNT_EN
        step(0, 4'd0, 6'd0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 5) idle(1);
            else step(1, 4'd4, 6'd0, 0, 0, 1);
        end
        idle(NS);
        check("retire_five", bus.retire_cnt, 5);
        step(0, 4'd0, 6'd0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) step(1, 4'd15, 6'd0, 0, 0, 1);
        idle(NS);
        check("retire_ffff", bus.retire_cnt, 16'hFFFF);
        step(1, 4'd15, 6'd0, 0, 0, 1);
        idle(NS);
        check("retire_wrap", bus.retire_cnt, 0);
`endif

        idle(2);
        @(negedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
